// File: rtl/lbus_target.sv
// ---------------------------------------------------------------------------
// lbus_target
//
// Local-bus slave. It holds the key and plaintext registers of a block-cipher
// core, launches the key schedule or an encryption, and captures the core
// result. A bus transaction has two phases: an address phase (one lbus_wrn
// strobe) followed by a data phase (lbus_wrn for a write, lbus_rdn for a
// read). Read data is registered and is valid one cycle after the address
// is captured, so it is already stable when the master pulses lbus_rdn.
//
// Ports
//   clk        in   1    rising-edge clock (bus and core)
//   reset_i    in   1    synchronous active-high reset
//   lbus_di_a  in   16   address (address phase) / write data (data phase)
//   lbus_do    out  16   registered read data
//   lbus_wrn   in   1    active-low address/write strobe
//   lbus_rdn   in   1    active-low read strobe
//   key_o      out  128  key register, word 0 = [127:112]
//   text_o     out  128  plaintext register, word 0 = [127:112]
//   start_o    out  1    one-cycle encryption launch pulse
//   keyset_o   out  1    one-cycle key-schedule launch pulse
//   done_i     in   1    one-cycle completion pulse from the core
//   result_i   in   128  core result, sampled when done_i=1
//
// Register map (word addresses)
//   0x0002          CONT  write: bit0 start, bit1 keyset, bit15 clear err
//                         read : {13'b0, err, rvalid, run}
//   0x0100-0x0107   KEY    word 0..7 (R/W, writes refused while running)
//   0x0140-0x0147   TEXT   word 0..7 (R/W, writes refused while running)
//   0x0180-0x0187   RESULT word 0..7 (RO)
//   0xFFFC          VERSION, reads 0x5A47
// ---------------------------------------------------------------------------
module lbus_target (
    input  logic         clk,
    input  logic         reset_i,
    input  logic [15:0]  lbus_di_a,
    output logic [15:0]  lbus_do,
    input  logic         lbus_wrn,
    input  logic         lbus_rdn,
    output logic [127:0] key_o,
    output logic [127:0] text_o,
    output logic         start_o,
    output logic         keyset_o,
    input  logic         done_i,
    input  logic [127:0] result_i
);

    typedef enum logic {
        ST_ADDR = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [15:0]    addr_r;
    logic [15:0]    do_r;
    logic [127:0]   key_r;
    logic [127:0]   text_r;
    logic [127:0]   result_r;
    logic           run_r;
    logic           rvalid_r;
    logic           err_r;
    logic           start_r;
    logic           keyset_r;

    logic           cap_s;
    logic           wr_s;
    logic           is_cont_s;
    logic           is_key_s;
    logic           is_text_s;
    logic           cont_ok_s;
    logic           start_go_s;
    logic           keyset_go_s;
    logic           done_ok_s;
    logic           err_set_s;
    logic           err_clr_s;
    logic [2:0]     status_s;

    // Word read mux. Word i of a 128-bit register lives at bits
    // [127-16*i -: 16]; since 7-i equals ~i for a 3-bit index, the low
    // bit position of the word is {~i, 4'b0}.
    function automatic logic [15:0] read_word(
        input logic [15:0]  a,
        input logic [127:0] key,
        input logic [127:0] text,
        input logic [127:0] result,
        input logic [2:0]   status
    );
        logic [6:0]  base;
        logic [15:0] word;
        base = {~a[2:0], 4'd0};
        if (a == 16'h0002) begin
            word = {13'd0, status};
        end else if (a[15:3] == 13'h0020) begin
            word = key[base +: 16];
        end else if (a[15:3] == 13'h0028) begin
            word = text[base +: 16];
        end else if (a[15:3] == 13'h0030) begin
            word = result[base +: 16];
        end else if (a == 16'hFFFC) begin
            word = 16'h5A47;
        end else begin
            word = 16'h0000;
        end
        return word;
    endfunction

    // Bus FSM next state: an address strobe opens the data phase, any strobe
    // in the data phase closes it, otherwise the data phase waits.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_ADDR: begin
                if (!lbus_wrn) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (!lbus_wrn || !lbus_rdn) begin
                    state_next_s = ST_ADDR;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            default: state_next_s = ST_ADDR;
        endcase
    end

    // Transaction decode and control/error qualification. A CONT write that
    // coincides with done_i still sees run=1 and is therefore refused.
    always_comb begin
        cap_s       = (state_r == ST_ADDR) && !lbus_wrn;
        wr_s        = (state_r == ST_DATA) && !lbus_wrn;
        is_cont_s   = (addr_r == 16'h0002);
        is_key_s    = (addr_r[15:3] == 13'h0020);
        is_text_s   = (addr_r[15:3] == 13'h0028);
        cont_ok_s   = wr_s && is_cont_s && !run_r;
        // keyset takes priority when both launch bits are written together
        keyset_go_s = cont_ok_s && lbus_di_a[1];
        start_go_s  = cont_ok_s && lbus_di_a[0] && !lbus_di_a[1];
        done_ok_s   = done_i && run_r;
        err_clr_s   = wr_s && is_cont_s && lbus_di_a[15];
        err_set_s   = ((state_r == ST_ADDR) && !lbus_rdn)
                    || (wr_s && !lbus_rdn)
                    || (wr_s && run_r && (is_key_s || is_text_s))
                    || (wr_s && run_r && is_cont_s && !lbus_di_a[15]);
        status_s    = {err_r, rvalid_r, run_r};
    end

    // Bus FSM state, captured address and registered read data. Read data
    // is taken from the incoming address at capture so it is valid in the
    // first data-phase cycle, then tracks the latched address; it holds
    // while idle in the address phase.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_r <= ST_ADDR;
            addr_r  <= 16'h0000;
            do_r    <= 16'h0000;
        end else begin
            state_r <= state_next_s;
            if (cap_s) begin
                addr_r <= lbus_di_a;
                do_r   <= read_word(lbus_di_a, key_r, text_r, result_r, status_s);
            end else if (state_r == ST_DATA) begin
                addr_r <= addr_r;
                do_r   <= read_word(addr_r, key_r, text_r, result_r, status_s);
            end else begin
                addr_r <= addr_r;
                do_r   <= do_r;
            end
        end
    end

    // KEY and TEXT word writes, refused while the core is running.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            key_r  <= 128'd0;
            text_r <= 128'd0;
        end else if (wr_s && !run_r) begin
            if (is_key_s) begin
                key_r[{~addr_r[2:0], 4'd0} +: 16] <= lbus_di_a;
            end else if (is_text_s) begin
                text_r[{~addr_r[2:0], 4'd0} +: 16] <= lbus_di_a;
            end else begin
                key_r  <= key_r;
                text_r <= text_r;
            end
        end else begin
            key_r  <= key_r;
            text_r <= text_r;
        end
    end

    // Core control: launch pulses, run/rvalid status, result capture and the
    // sticky error flag. Launch is only possible with run=0 and sets run, so
    // two launch pulses can never be adjacent.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            start_r  <= 1'b0;
            keyset_r <= 1'b0;
            run_r    <= 1'b0;
            rvalid_r <= 1'b0;
            result_r <= 128'd0;
            err_r    <= 1'b0;
        end else begin
            start_r  <= start_go_s;
            keyset_r <= keyset_go_s;
            err_r    <= (err_r && !err_clr_s) || err_set_s;
            if (done_ok_s) begin
                run_r    <= 1'b0;
                rvalid_r <= 1'b1;
                result_r <= result_i;
            end else if (start_go_s || keyset_go_s) begin
                run_r    <= 1'b1;
                rvalid_r <= 1'b0;
                result_r <= result_r;
            end else begin
                run_r    <= run_r;
                rvalid_r <= rvalid_r;
                result_r <= result_r;
            end
        end
    end

    assign lbus_do  = do_r;
    assign key_o    = key_r;
    assign text_o   = text_r;
    assign start_o  = start_r;
    assign keyset_o = keyset_r;

endmodule

// File: tb/tb_lbus_target.sv
// ---------------------------------------------------------------------------
// tb_lbus_target
//
// Scoreboard bench for lbus_target. Bus tasks update a word-level model of
// the register file and push expected read data / launch pulses into queues;
// a monitor on the falling clock edge pops and compares whenever the DUT
// completes a read or raises start_o/keyset_o.
// ---------------------------------------------------------------------------
module tb_lbus_target;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [15:0]  lbus_di_a;
    logic [15:0]  lbus_do;
    logic         lbus_wrn;
    logic         lbus_rdn;
    logic [127:0] key_o;
    logic [127:0] text_o;
    logic         start_o;
    logic         keyset_o;
    logic         done_i;
    logic [127:0] result_i;

    lbus_target dut (
        .clk       (clk),
        .reset_i   (reset_i),
        .lbus_di_a (lbus_di_a),
        .lbus_do   (lbus_do),
        .lbus_wrn  (lbus_wrn),
        .lbus_rdn  (lbus_rdn),
        .key_o     (key_o),
        .text_o    (text_o),
        .start_o   (start_o),
        .keyset_o  (keyset_o),
        .done_i    (done_i),
        .result_i  (result_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: register file as word arrays plus status flags
    logic [15:0] m_key  [8];
    logic [15:0] m_text [8];
    logic [15:0] m_res  [8];
    bit          m_run;
    bit          m_rvalid;
    bit          m_err;

    typedef struct {
        logic [15:0] a;
        logic [15:0] v;
    } rd_t;

    rd_t        rd_q[$];
    logic [1:0] pulse_q[$];   // 2'b10 = start, 2'b01 = keyset
    logic       rd_chk = 1'b0;

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < 8; i++) begin
            m_key[i]  = 16'h0000;
            m_text[i] = 16'h0000;
            m_res[i]  = 16'h0000;
        end
        m_run    = 1'b0;
        m_rvalid = 1'b0;
        m_err    = 1'b0;
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a);
        if (a == 16'h0002)                        return {13'd0, m_err, m_rvalid, m_run};
        if (a >= 16'h0100 && a <= 16'h0107)       return m_key[a[2:0]];
        if (a >= 16'h0140 && a <= 16'h0147)       return m_text[a[2:0]];
        if (a >= 16'h0180 && a <= 16'h0187)       return m_res[a[2:0]];
        if (a == 16'hFFFC)                        return 16'h5A47;
        return 16'h0000;
    endfunction

    function automatic void m_write(input logic [15:0] a, input logic [15:0] d);
        if (a == 16'h0002) begin
            if (m_run) begin
                if (!d[15]) m_err = 1'b1;
            end else if (d[1]) begin
                pulse_q.push_back(2'b01);
                m_run = 1'b1;
                m_rvalid = 1'b0;
            end else if (d[0]) begin
                pulse_q.push_back(2'b10);
                m_run = 1'b1;
                m_rvalid = 1'b0;
            end
            if (d[15]) m_err = 1'b0;
        end else if (a >= 16'h0100 && a <= 16'h0107) begin
            if (m_run) m_err = 1'b1; else m_key[a[2:0]] = d;
        end else if (a >= 16'h0140 && a <= 16'h0147) begin
            if (m_run) m_err = 1'b1; else m_text[a[2:0]] = d;
        end
    endfunction

    function automatic void m_done(input logic [127:0] r);
        if (m_run) begin
            for (int i = 0; i < 8; i++) m_res[i] = r[127 - 16*i -: 16];
            m_run    = 1'b0;
            m_rvalid = 1'b1;
        end
    endfunction

    function automatic logic [127:0] m_key_vec();
        return {m_key[0], m_key[1], m_key[2], m_key[3], m_key[4], m_key[5], m_key[6], m_key[7]};
    endfunction

    function automatic logic [127:0] m_text_vec();
        return {m_text[0], m_text[1], m_text[2], m_text[3], m_text[4], m_text[5], m_text[6], m_text[7]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [15:0] a);
        lbus_di_a = a;
        lbus_wrn  = 1'b0;
        cyc();
        lbus_wrn  = 1'b1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input int gap);
        addr_phase(a);
        repeat (gap) cyc();
        lbus_di_a = d;
        lbus_wrn  = 1'b0;
        m_write(a, d);
        cyc();
        lbus_wrn  = 1'b1;
    endtask

    task automatic bus_read(input logic [15:0] a, input int gap);
        rd_t e;
        addr_phase(a);
        repeat (gap) cyc();
        e.a = a;
        e.v = m_read(a);
        rd_q.push_back(e);
        lbus_rdn = 1'b0;
        rd_chk   = 1'b1;
        cyc();
        lbus_rdn = 1'b1;
        rd_chk   = 1'b0;
    endtask

    task automatic core_done(input logic [127:0] r);
        done_i   = 1'b1;
        result_i = r;
        m_done(r);
        cyc();
        done_i   = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0;
        m_clear();
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: compare completed reads and launch pulses against the queues.
    always @(negedge clk) begin
        rd_t e;
        logic [1:0] k;
        if (rd_chk && !lbus_rdn) begin
            if (rd_q.size() == 0) begin
                check16("read_queue_empty", lbus_do, 16'hxxxx);
            end else begin
                e = rd_q.pop_front();
                check16($sformatf("read_%h", e.a), lbus_do, e.v);
            end
        end
        if (start_o || keyset_o) begin
            if (pulse_q.size() == 0) begin
                check16("unexpected_pulse", {14'd0, start_o, keyset_o}, 16'h0000);
            end else begin
                k = pulse_q.pop_front();
                check16("launch_pulse", {14'd0, start_o, keyset_o}, {14'd0, k});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r;
        logic [15:0] a;
        logic [15:0] d;

        reset_i   = 1'b1;
        lbus_di_a = 16'h0000;
        lbus_wrn  = 1'b1;
        lbus_rdn  = 1'b1;
        done_i    = 1'b0;
        result_i  = 128'd0;
        repeat (3) cyc();
        reset_i = 1'b0;
        m_clear();

        // reset state
        check128("reset_key", key_o, 128'd0);
        check128("reset_text", text_o, 128'd0);
        check16("reset_do", lbus_do, 16'h0000);
        check16("reset_pulses", {14'd0, start_o, keyset_o}, 16'h0000);
        bus_read(16'h0002, 0);

        // key word write / readback and output ordering
        bus_write(16'h0100, 16'h2B7E, 0);
        bus_write(16'h0107, 16'h3C4F, 1);
        bus_read(16'h0100, 0);
        check16("key_word0", key_o[127:112], 16'h2B7E);
        check16("key_word7", key_o[15:0], 16'h3C4F);
        check128("key_vec", key_o, m_key_vec());

        // start, then completion
        bus_write(16'h0002, 16'h0001, 0);
        bus_read(16'h0002, 0);
        core_done(128'h3925841D02DC09FBDC118597196A0B32);
        bus_read(16'h0002, 0);
        bus_read(16'h0180, 0);
        bus_read(16'h0187, 1);

        // refused writes while running, err clear
        bus_write(16'h0002, 16'h0001, 0);
        bus_write(16'h0140, 16'hFFFF, 0);
        bus_write(16'h0002, 16'h0001, 0);
        check128("text_locked", text_o, m_text_vec());
        bus_read(16'h0002, 0);
        bus_write(16'h0002, 16'h8000, 0);
        bus_read(16'h0002, 0);
        core_done(rand128());

        // long data-phase wait, undecoded and version reads
        bus_read(16'h0002, 5);
        bus_read(16'h1234, 0);
        bus_read(16'hFFFC, 2);

        // both launch bits: keyset only; done while idle is ignored
        bus_write(16'h0002, 16'h0003, 0);
        core_done(rand128());
        core_done(rand128());
        bus_read(16'h0183, 0);
        bus_read(16'h0002, 0);

        // reset between address and data phase of a key write
        addr_phase(16'h0100);
        do_reset();
        bus_write(16'h0140, 16'hABCD, 0);
        check128("key_after_midreset", key_o, 128'd0);
        check128("text_after_midreset", text_o, m_text_vec());

        // simultaneous write and read strobes in the data phase
        addr_phase(16'h0101);
        lbus_di_a = 16'h1111;
        lbus_wrn  = 1'b0;
        lbus_rdn  = 1'b0;
        m_write(16'h0101, 16'h1111);
        m_err = 1'b1;
        cyc();
        lbus_wrn = 1'b1;
        lbus_rdn = 1'b1;
        bus_read(16'h0101, 0);
        bus_read(16'h0002, 0);
        bus_write(16'h0002, 16'h8000, 0);

        // read strobe in the address phase is an error
        lbus_rdn = 1'b0;
        m_err    = 1'b1;
        cyc();
        lbus_rdn = 1'b1;
        bus_read(16'h0002, 0);
        bus_write(16'h0002, 16'h8000, 0);

        // CONT write on the same edge as done_i is refused
        bus_write(16'h0002, 16'h0001, 0);
        addr_phase(16'h0002);
        lbus_di_a = 16'h0001;
        lbus_wrn  = 1'b0;
        done_i    = 1'b1;
        result_i  = rand128();
        m_write(16'h0002, 16'h0001);
        m_done(result_i);
        cyc();
        lbus_wrn = 1'b1;
        done_i   = 1'b0;
        bus_read(16'h0002, 0);
        bus_read(16'h0185, 0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            case (r[2:0])
                3'd0: bus_write({13'h0020, r[5:3]}, r[31:16], int'(r[7:6] % 2'd3));
                3'd1: bus_write({13'h0028, r[5:3]}, r[31:16], int'(r[7:6] % 2'd3));
                3'd2: begin
                    case (r[9:8])
                        2'd0:    a = {13'h0020, r[5:3]};
                        2'd1:    a = {13'h0028, r[5:3]};
                        2'd2:    a = {13'h0030, r[5:3]};
                        default: a = 16'hFFFC;
                    endcase
                    bus_read(a, int'(r[7:6] % 2'd3));
                end
                3'd3: begin
                    d = {r[10], 13'd0, r[12:11]};
                    bus_write(16'h0002, d, int'(r[7:6] % 2'd3));
                end
                3'd4: core_done(rand128());
                3'd5: bus_read(r[31:16], 0);
                3'd6: bus_read(16'h0002, int'(r[7:6] % 2'd3));
                default: bus_write(r[31:16], r[15:0], 0);
            endcase
        end
        cyc();
        check128("final_key", key_o, m_key_vec());
        check128("final_text", text_o, m_text_vec());
        check16("pulse_queue_drained", 16'(pulse_q.size()), 16'd0);
        check16("read_queue_drained", 16'(rd_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
